// File: rtl/display_sched_pkg.sv
// Shared types for the display source scheduler.
// State encoding and index-width helper.
package display_sched_pkg;

  typedef enum logic [1:0] {
    NONE,
    SHOW,
    BLANK
  } sched_state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/display_source_scheduler_if.sv
// Source-side and display-side bundle of the scheduler.
// slave = scheduler view, master = environment view.
interface display_source_scheduler_if #(
  parameter int NUM_SRC = 4,
  parameter int DIGITS  = 2
);

  localparam int SW = display_sched_pkg::idx_w(NUM_SRC);

  logic [DIGITS-1:0][3:0] src_encoded [NUM_SRC];
  logic [DIGITS-1:0]      src_digit_point [NUM_SRC];
  logic [NUM_SRC-1:0]     src_valid;
  logic                   btn_next;
  logic                   btn_mode;

  logic [DIGITS-1:0][3:0] encoded;
  logic [DIGITS-1:0]      digit_point;
  logic                   blank;
  logic [SW-1:0]          sel;
  logic [NUM_SRC-1:0]     sel_onehot;
  logic                   auto_mode;

  modport slave (
    input  src_encoded,
    input  src_digit_point,
    input  src_valid,
    input  btn_next,
    input  btn_mode,
    output encoded,
    output digit_point,
    output blank,
    output sel,
    output sel_onehot,
    output auto_mode
  );

  modport master (
    output src_encoded,
    output src_digit_point,
    output src_valid,
    output btn_next,
    output btn_mode,
    input  encoded,
    input  digit_point,
    input  blank,
    input  sel,
    input  sel_onehot,
    input  auto_mode
  );

endinterface

// File: rtl/rr_next_index.sv
// Round-robin search: first set bit of valid after current.
// Wraps to 0; returns current itself only if it is the sole hit.
module rr_next_index
  import display_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] current,
  output logic [W-1:0] next,
  output logic         found
);

  logic [W-1:0] cand;

  // Scan far-to-near so the nearest hit is assigned last and wins
  always_comb begin
    next  = current;
    found = |valid;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = W'((int'(current) + k) % N);
      if (valid[cand]) next = cand;
    end
  end

endmodule

// File: rtl/display_source_scheduler.sv
// Time-shares one seven-segment display between sources.
// Auto/manual rotation with a blank gap between sources.
module display_source_scheduler
  import display_sched_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DIGITS       = 2,
  parameter int DWELL_CYCLES = 200_000_000,
  parameter int BLANK_CYCLES = 5_000_000
) (
  input logic                        clk,
  input logic                        reset,
  display_source_scheduler_if.slave  bus
);

  localparam int SW = idx_w(NUM_SRC);
  localparam int DW = idx_w(DWELL_CYCLES);
  localparam int BW = idx_w(BLANK_CYCLES);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [SW-1:0] TOP_IDX    = SW'(NUM_SRC - 1);

  sched_state_t state_q, state_d;

  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] pend_q, pend_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          auto_q, auto_d;
  logic          blank_q, blank_d;

  logic [NUM_SRC-1:0]     oh_q, oh_d;
  logic [DIGITS-1:0][3:0] enc_q, enc_d;
  logic [DIGITS-1:0]      dp_q, dp_d;

  logic [SW-1:0] rr_cur;
  logic [SW-1:0] rr_next;
  logic          rr_found;
  logic          adv;

  // Search origin: NONE finds lowest, SHOW advances, BLANK re-searches
  always_comb begin
    rr_cur = sel_q;
    unique case (state_q)
      NONE:    rr_cur = TOP_IDX;
      SHOW:    rr_cur = sel_q;
      BLANK:   rr_cur = pend_q;
      default: rr_cur = sel_q;
    endcase
  end

  rr_next_index #(
    .N (NUM_SRC),
    .W (SW)
  ) u_rr (
    .valid   (bus.src_valid),
    .current (rr_cur),
    .next    (rr_next),
    .found   (rr_found)
  );

  // Next-state, counters and registered display outputs
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    auto_d  = auto_q ^ bus.btn_mode;
    dwell_d = '0;
    bcnt_d  = '0;
    adv     = 1'b0;

    unique case (state_q)
      NONE: begin
        if (rr_found) begin
          state_d = SHOW;
          sel_d   = rr_next;
        end
      end
      SHOW: begin
        adv = bus.btn_next
            | (auto_q & (dwell_q == DWELL_LAST))
            | ~bus.src_valid[sel_q];
        if (adv) begin
          if (!rr_found) begin
            state_d = NONE;
          end else if (rr_next != sel_q) begin
            state_d = BLANK;
            pend_d  = rr_next;
          end
        end else if (auto_q && !bus.btn_mode) begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      BLANK: begin
        if (bcnt_q == BLANK_LAST) begin
          if (bus.src_valid[pend_q]) begin
            state_d = SHOW;
            sel_d   = pend_q;
          end else if (rr_found) begin
            state_d = SHOW;
            sel_d   = rr_next;
          end else begin
            state_d = NONE;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = NONE;
    endcase

    blank_d = (state_d != SHOW);
    oh_d    = '0;
    enc_d   = enc_q;
    dp_d    = dp_q;
    if (state_d == SHOW) begin
      oh_d  = NUM_SRC'(1) << sel_d;
      enc_d = bus.src_encoded[sel_d];
      dp_d  = bus.src_digit_point[sel_d];
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= NONE;
      sel_q   <= '0;
      pend_q  <= '0;
      dwell_q <= '0;
      bcnt_q  <= '0;
      auto_q  <= 1'b1;
      blank_q <= 1'b1;
      oh_q    <= '0;
      enc_q   <= '0;
      dp_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      dwell_q <= dwell_d;
      bcnt_q  <= bcnt_d;
      auto_q  <= auto_d;
      blank_q <= blank_d;
      oh_q    <= oh_d;
      enc_q   <= enc_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.encoded     = enc_q;
  assign bus.digit_point = dp_q;
  assign bus.blank       = blank_q;
  assign bus.sel         = sel_q;
  assign bus.sel_onehot  = oh_q;
  assign bus.auto_mode   = auto_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Scoreboard bench for display_source_scheduler.
// Expected show/blank events are queued; a monitor pops them.
module tb_display_source_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;

  display_source_scheduler_if #(
    .NUM_SRC (4),
    .DIGITS  (2)
  ) bus ();

  display_source_scheduler #(
    .NUM_SRC      (4),
    .DIGITS       (2),
    .DWELL_CYCLES (10),
    .BLANK_CYCLES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       kind;
    int       sel;
    logic [7:0] enc;
    logic [1:0] dp;
    int       gap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  bit   mon_en = 0;
  logic prev_blank = 1'b1;
  logic [1:0] prev_sel = '0;

  task automatic push_s(input int s, input int gap);
    exp_t e;
    e.kind = 1'b1;
    e.sel  = s;
    e.enc  = 8'(8'h10 + s);
    e.dp   = 2'(s);
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic push_b(input int s, input int gap);
    exp_t e;
    e.kind = 1'b0;
    e.sel  = s;
    e.enc  = 8'h00;
    e.dp   = 2'b00;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    bit   ev;
    bit   kind;
    bit   ok;
    int   gap;
    exp_t e;
    logic [3:0] eoh;
    @(negedge clk);
    ev   = 1'b0;
    kind = 1'b0;
    if (mon_en) begin
      if (prev_blank && !bus.blank) begin
        ev = 1'b1; kind = 1'b1;
      end else if (!prev_blank && bus.blank) begin
        ev = 1'b1; kind = 1'b0;
      end else if (!bus.blank && bus.sel != prev_sel) begin
        ev = 1'b1; kind = 1'b1;
      end
      if (ev) begin
        n_cmp++;
        gap = cyc - last_cyc;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL event: unexpected kind=%0d sel=%0d cyc=%0d, required none",
                   kind, bus.sel, cyc);
        end else begin
          e   = sb.pop_front();
          eoh = e.kind ? (4'b0001 << e.sel) : 4'b0000;
          ok  = (kind == e.kind) && (int'(bus.sel) == e.sel)
             && (bus.sel_onehot == eoh)
             && (e.gap < 0 || gap == e.gap);
          if (e.kind)
            ok = ok && (bus.encoded == e.enc) && (bus.digit_point == e.dp);
          if (!ok)
            $display("FAIL event: got k=%0d sel=%0d oh=%b enc=%h dp=%b gap=%0d required k=%0d sel=%0d oh=%b enc=%h dp=%b gap=%0d",
                     kind, bus.sel, bus.sel_onehot, bus.encoded, bus.digit_point, gap,
                     e.kind, e.sel, eoh, e.enc, e.dp, e.gap);
          if (!ok) n_err++;
        end
        last_cyc = cyc;
      end
    end
    prev_blank = bus.blank;
    prev_sel   = bus.sel;
  end

  task automatic start(input logic [3:0] v);
    mon_en = 1'b0;
    @(negedge clk);
    reset         = 1'b1;
    bus.src_valid = v;
    bus.btn_next  = 1'b0;
    bus.btn_mode  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_blank", int'(bus.blank), 1);
    chk("rst_sel", int'(bus.sel), 0);
    chk("rst_onehot", int'(bus.sel_onehot), 0);
    chk("rst_enc", int'(bus.encoded), 0);
    chk("rst_dp", int'(bus.digit_point), 0);
    chk("rst_auto", int'(bus.auto_mode), 1);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic pulse_next();
    bus.btn_next = 1'b1;
    @(negedge clk);
    bus.btn_next = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      bus.src_encoded[i]     = 8'(8'h10 + i);
      bus.src_digit_point[i] = 2'(i);
    end
    bus.src_valid = 4'b0000;
    bus.btn_next  = 1'b0;
    bus.btn_mode  = 1'b0;

    // full rotation 0,1,2,3,0 with 10 show + 3 blank
    push_s(0, -1);
    for (int s = 1; s <= 4; s++) begin
      push_b((s - 1) % 4, 10);
      push_s(s % 4, 3);
    end
    start(4'b1111);
    repeat (56) @(negedge clk);
    chk("rot_drain", sb.size(), 0);

    // sparse mask alternates 1,3,1
    push_s(1, -1);
    push_b(1, 10); push_s(3, 3);
    push_b(3, 10); push_s(1, 3);
    start(4'b1010);
    repeat (32) @(negedge clk);
    chk("sparse_drain", sb.size(), 0);

    // manual mode, button advances, pulse in blank ignored
    push_s(0, -1);
    start(4'b1111);
    repeat (3) @(negedge clk);
    bus.btn_mode = 1'b1;
    @(negedge clk);
    bus.btn_mode = 1'b0;
    repeat (100) @(negedge clk);
    chk("man_auto", int'(bus.auto_mode), 0);
    chk("man_blank", int'(bus.blank), 0);
    push_b(0, -1); push_s(1, 3);
    pulse_next();
    pulse_next();
    repeat (10) @(negedge clk);
    chk("man_sel1", int'(bus.sel), 1);
    push_b(1, -1); push_s(2, 3);
    pulse_next();
    repeat (10) @(negedge clk);
    chk("man_drain", sb.size(), 0);
    chk("man_sel2", int'(bus.sel), 2);

    // sole source, then none, then restore
    push_s(2, -1);
    start(4'b0100);
    repeat (30) @(negedge clk);
    push_b(2, -1); push_s(2, 4);
    bus.src_valid = 4'b0000;
    repeat (4) @(negedge clk);
    chk("none_blank", int'(bus.blank), 1);
    chk("none_onehot", int'(bus.sel_onehot), 0);
    bus.src_valid = 4'b0100;
    repeat (3) @(negedge clk);
    chk("rest_blank", int'(bus.blank), 0);
    chk("rest_onehot", int'(bus.sel_onehot), 4);
    chk("sole_drain", sb.size(), 0);

    // button coincident with dwell expiry: one advance
    push_s(0, -1);
    push_b(0, 10); push_s(1, 3);
    push_b(1, 10); push_s(2, 3);
    start(4'b1111);
    repeat (10) @(negedge clk);
    pulse_next();
    repeat (18) @(negedge clk);
    chk("coinc_drain", sb.size(), 0);

    // pending source dropped during blank
    push_s(0, -1);
    push_b(0, 10); push_s(2, 3);
    start(4'b1111);
    repeat (11) @(negedge clk);
    bus.src_valid = 4'b1101;
    repeat (6) @(negedge clk);
    chk("resrch_drain", sb.size(), 0);

    // async reset in blank
    push_s(0, -1); push_b(0, -1);
    start(4'b1111);
    repeat (3) @(negedge clk);
    bus.btn_mode = 1'b1;
    @(negedge clk);
    bus.btn_mode = 1'b0;
    pulse_next();
    #2;
    chk("arst_drain", sb.size(), 0);
    chk("arst_pre_auto", int'(bus.auto_mode), 0);
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("arst_blank", int'(bus.blank), 1);
    chk("arst_enc", int'(bus.encoded), 0);
    chk("arst_auto", int'(bus.auto_mode), 1);
    chk("arst_onehot", int'(bus.sel_onehot), 0);
    chk("arst_sel", int'(bus.sel), 0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
